uart_transceiver: RTL and testbench

8N1 UART serial port with an independent transmitter and receiver sharing one clock. The SoC IO page drives it directly. Byte writes to the TX data word start a transmission. The RX data word returns the last received byte. The CTRL word exposes `!o_Tx_Active` and `o_Rx_DV`. Each direction is a self-timed bit-rate state machine with no FIFO.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_sync2.sv | 25 ++
 rtl/uart_transceiver.sv | 195 +++++++++++++++++++
 tb/tb_uart_transceiver.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding and frame constants for the 8N1 UART
// Contents: uart_state_t (IDLE/START/DATA/STOP, used by TX and RX FSMs),
//           DEFAULT_CLKS_PER_BIT, DATA_BITS, START_BIT, STOP_BIT.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  // 27 MHz system clock / 115200 baud
  localparam int DEFAULT_CLKS_PER_BIT = 234;

  localparam int   DATA_BITS = 8;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_sync2.sv
// rtl/uart_sync2.sv - two-flop synchronizer for the asynchronous RX line
// Ports: clk  - system clock
//        rst  - asynchronous active-high reset, both flops go to 1 (idle line)
//        d    - asynchronous input
//        q    - synchronized output
module uart_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_transceiver.sv
// rtl/uart_transceiver.sv - 8N1 UART with independent TX and RX bit-rate FSMs
// Parameter: CLKS_PER_BIT - clock cycles per serial bit (minimum 4)
// Ports: i_Clock, i_Reset (async, active-high)
//        TX: i_Tx_DV, i_Tx_Byte -> o_Tx_Active, o_Tx_Serial, o_Tx_Done
//        RX: i_Rx_Serial -> o_Rx_DV, o_Rx_Byte, o_Rx_Frame_Err
module uart_transceiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Tx_DV,
  input  logic [7:0] i_Tx_Byte,
  output logic       o_Tx_Active,
  output logic       o_Tx_Serial,
  output logic       o_Tx_Done,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Frame_Err
);

  localparam int              CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   CNT_HALF = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [2:0]      IDX_LAST = 3'(DATA_BITS - 1);

  // ---------------------------------------------------------------- TX
  uart_state_t   tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_idx;
  logic [7:0]    tx_data;

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      tx_state    <= IDLE;
      tx_cnt      <= '0;
      tx_idx      <= '0;
      tx_data     <= '0;
      o_Tx_Active <= 1'b0;
      o_Tx_Serial <= STOP_BIT;
      o_Tx_Done   <= 1'b0;
    end else begin
      o_Tx_Done <= 1'b0;
      case (tx_state)
        IDLE: begin
          o_Tx_Serial <= STOP_BIT;
          tx_cnt      <= '0;
          tx_idx      <= '0;
          // Accepting here also covers the cycle Done is high, so a host
          // reacting to Done starts the next frame straight away.
          if (i_Tx_DV) begin
            tx_data     <= i_Tx_Byte;
            o_Tx_Active <= 1'b1;
            o_Tx_Serial <= START_BIT;
            tx_state    <= START;
          end
        end
        START: begin
          if (tx_cnt == CNT_LAST) begin
            tx_cnt      <= '0;
            o_Tx_Serial <= tx_data[0];
            tx_state    <= DATA;
          end else begin
            tx_cnt <= tx_cnt + CNT_ONE;
          end
        end
        DATA: begin
          if (tx_cnt == CNT_LAST) begin
            tx_cnt <= '0;
            if (tx_idx == IDX_LAST) begin
              tx_idx      <= '0;
              o_Tx_Serial <= STOP_BIT;
              tx_state    <= STOP;
            end else begin
              tx_idx      <= tx_idx + 3'd1;
              o_Tx_Serial <= tx_data[tx_idx + 3'd1];
            end
          end else begin
            tx_cnt <= tx_cnt + CNT_ONE;
          end
        end
        STOP: begin
          if (tx_cnt == CNT_LAST) begin
            tx_cnt      <= '0;
            o_Tx_Active <= 1'b0;
            o_Tx_Done   <= 1'b1;
            tx_state    <= IDLE;
          end else begin
            tx_cnt <= tx_cnt + CNT_ONE;
          end
        end
        default: begin
          tx_state    <= IDLE;
          o_Tx_Serial <= STOP_BIT;
          o_Tx_Active <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------- RX
  logic rx_sync;

  uart_sync2 u_rx_sync (
    .clk (i_Clock),
    .rst (i_Reset),
    .d   (i_Rx_Serial),
    .q   (rx_sync)
  );

  uart_state_t   rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_idx;
  logic [7:0]    rx_shift;
  // Cleared by a framing error; a start bit is only honoured once the line
  // has been seen high again, so a held-low break cannot retrigger RX.
  logic          armed;

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      rx_state       <= IDLE;
      rx_cnt         <= '0;
      rx_idx         <= '0;
      rx_shift       <= '0;
      armed          <= 1'b0;
      o_Rx_DV        <= 1'b0;
      o_Rx_Byte      <= '0;
      o_Rx_Frame_Err <= 1'b0;
    end else begin
      o_Rx_DV        <= 1'b0;
      o_Rx_Frame_Err <= 1'b0;
      if (rx_sync == STOP_BIT) begin
        armed <= 1'b1;
      end
      case (rx_state)
        IDLE: begin
          rx_cnt <= '0;
          rx_idx <= '0;
          if (rx_sync == START_BIT && armed) begin
            rx_state <= START;
          end
        end
        START: begin
          if (rx_cnt == CNT_HALF) begin
            rx_cnt <= '0;
            // A start bit that is gone by mid-bit was a glitch.
            if (rx_sync == START_BIT) begin
              rx_state <= DATA;
            end else begin
              rx_state <= IDLE;
            end
          end else begin
            rx_cnt <= rx_cnt + CNT_ONE;
          end
        end
        DATA: begin
          if (rx_cnt == CNT_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_sync, rx_shift[7:1]};
            if (rx_idx == IDX_LAST) begin
              rx_idx   <= '0;
              rx_state <= STOP;
            end else begin
              rx_idx <= rx_idx + 3'd1;
            end
          end else begin
            rx_cnt <= rx_cnt + CNT_ONE;
          end
        end
        STOP: begin
          if (rx_cnt == CNT_LAST) begin
            rx_cnt   <= '0;
            rx_state <= IDLE;
            if (rx_sync == STOP_BIT) begin
              o_Rx_Byte <= rx_shift;
              o_Rx_DV   <= 1'b1;
            end else begin
              o_Rx_Frame_Err <= 1'b1;
              armed          <= 1'b0;
            end
          end else begin
            rx_cnt <= rx_cnt + CNT_ONE;
          end
        end
        default: begin
          rx_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transceiver.sv
// tb/tb_uart_transceiver.sv - directed self-checking bench for uart_transceiver
module tb_uart_transceiver;

  localparam int C = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_dv = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic       tx_active;
  logic       tx_serial;
  logic       tx_done;
  logic       rx_serial;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic       rx_err;

  logic       loop = 1'b0;
  logic       rx_drv = 1'b1;

  assign rx_serial = loop ? tx_serial : rx_drv;

  always #5 clk = ~clk;

  uart_transceiver #(.CLKS_PER_BIT(C)) dut (
    .i_Clock        (clk),
    .i_Reset        (rst),
    .i_Tx_DV        (tx_dv),
    .i_Tx_Byte      (tx_byte),
    .o_Tx_Active    (tx_active),
    .o_Tx_Serial    (tx_serial),
    .o_Tx_Done      (tx_done),
    .i_Rx_Serial    (rx_serial),
    .o_Rx_DV        (rx_dv),
    .o_Rx_Byte      (rx_byte),
    .o_Rx_Frame_Err (rx_err)
  );

  int errors = 0;
  int checks = 0;

  int done_count = 0;
  int dv_count = 0;
  int err_count = 0;
  int active_count = 0;
  logic [7:0] rx_log [0:63];

  always @(negedge clk) begin
    if (tx_done) done_count++;
    if (tx_active) active_count++;
    if (rx_err) err_count++;
    if (rx_dv) begin
      if (dv_count < 64) rx_log[dv_count] = rx_byte;
      dv_count++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where Done is seen.
  task automatic send_tx(input logic [7:0] b);
    int n;
    tx_dv   = 1'b1;
    tx_byte = b;
    @(negedge clk);
    tx_dv   = 1'b0;
    tx_byte = 8'h00;
    n = 0;
    while (!tx_done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("tx_done_seen", {31'd0, tx_done}, 32'd1);
  endtask

  task automatic wait_dv(input int target);
    int n;
    n = 0;
    while (dv_count < target && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rx_dv_seen", (dv_count >= target) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic drive_frame(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      rx_drv = f[k];
      repeat (C) @(negedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int done_b, dv_b, err_b, act_b;
    logic [9:0] exp_a5;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_serial", {31'd0, tx_serial}, 32'd1);
    check("rst_active", {31'd0, tx_active}, 32'd0);
    check("rst_done",   {31'd0, tx_done},   32'd0);
    check("rst_dv",     {31'd0, rx_dv},     32'd0);
    check("rst_byte",   {24'd0, rx_byte},   32'h00);
    check("rst_err",    {31'd0, rx_err},    32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // TX 0xA5: serial 0,1,0,1,0,0,1,0,1,1 (bit 0 first)
    exp_a5 = 10'b1101001010;
    done_b = done_count;
    act_b  = active_count;
    tx_dv = 1'b1;
    tx_byte = 8'hA5;
    @(negedge clk);
    tx_dv = 1'b0;
    tx_byte = 8'h00;
    check("tx_start_active", {31'd0, tx_active}, 32'd1);
    check("tx_start_serial", {31'd0, tx_serial}, 32'd0);
    for (int k = 0; k < 10; k++) begin
      repeat (3) @(negedge clk);
      check($sformatf("tx_a5_bit%0d", k), {31'd0, tx_serial}, {31'd0, exp_a5[k]});
      repeat (5) @(negedge clk);
    end
    check("tx_done_pulse", {31'd0, tx_done}, 32'd1);
    check("tx_end_active", {31'd0, tx_active}, 32'd0);
    repeat (10) @(negedge clk);
    check("tx_active_cycles", active_count - act_b, 32'd80);
    check("tx_done_count", done_count - done_b, 32'd1);
    check("tx_idle_serial", {31'd0, tx_serial}, 32'd1);

    // Loopback 0x00, 0xFF, 0x3C, each DV issued in the previous Done cycle
    loop = 1'b1;
    dv_b = dv_count;
    err_b = err_count;
    send_tx(8'h00);
    send_tx(8'hFF);
    send_tx(8'h3C);
    wait_dv(dv_b + 3);
    repeat (20) @(negedge clk);
    check("loop_dv_count", dv_count - dv_b, 32'd3);
    check("loop_byte0", {24'd0, rx_log[dv_b]},     32'h00);
    check("loop_byte1", {24'd0, rx_log[dv_b + 1]}, 32'hFF);
    check("loop_byte2", {24'd0, rx_log[dv_b + 2]}, 32'h3C);
    check("loop_err", err_count - err_b, 32'd0);

    // DV with 0x11 during an active frame is ignored
    done_b = done_count;
    dv_b = dv_count;
    tx_dv = 1'b1;
    tx_byte = 8'hC3;
    @(negedge clk);
    tx_dv = 1'b0;
    repeat (30) @(negedge clk);
    tx_dv = 1'b1;
    tx_byte = 8'h11;
    @(negedge clk);
    tx_dv = 1'b0;
    tx_byte = 8'h00;
    wait_dv(dv_b + 1);
    repeat (150) @(negedge clk);
    check("ignore_done_count", done_count - done_b, 32'd1);
    check("ignore_dv_count", dv_count - dv_b, 32'd1);
    check("ignore_byte", {24'd0, rx_log[dv_b]}, 32'hC3);

    // 2-cycle glitch: no outputs, then a real frame is still received
    loop = 1'b0;
    rx_drv = 1'b1;
    repeat (4) @(negedge clk);
    dv_b = dv_count;
    err_b = err_count;
    rx_drv = 1'b0;
    repeat (2) @(negedge clk);
    rx_drv = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_dv", dv_count - dv_b, 32'd0);
    check("glitch_err", err_count - err_b, 32'd0);
    drive_frame(8'h96, 1'b1);
    repeat (10) @(negedge clk);
    check("post_glitch_dv", dv_count - dv_b, 32'd1);
    check("post_glitch_byte", {24'd0, rx_byte}, 32'h96);

    // 0x55 with stop low, line then held low as a break
    dv_b = dv_count;
    err_b = err_count;
    drive_frame(8'h55, 1'b0);
    rx_drv = 1'b0;
    repeat (200) @(negedge clk);
    check("ferr_count", err_count - err_b, 32'd1);
    check("ferr_dv", dv_count - dv_b, 32'd0);
    check("ferr_byte_kept", {24'd0, rx_byte}, 32'h96);
    rx_drv = 1'b1;
    repeat (10) @(negedge clk);
    drive_frame(8'h42, 1'b1);
    repeat (10) @(negedge clk);
    check("post_ferr_dv", dv_count - dv_b, 32'd1);
    check("post_ferr_byte", {24'd0, rx_byte}, 32'h42);

    // Reset mid-transmit and mid-receive
    done_b = done_count;
    dv_b = dv_count;
    err_b = err_count;
    tx_dv = 1'b1;
    tx_byte = 8'hF0;
    @(negedge clk);
    tx_dv = 1'b0;
    tx_byte = 8'h00;
    rx_drv = 1'b0;
    repeat (25) @(negedge clk);
    check("pre_rst_serial", {31'd0, tx_serial}, 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_serial", {31'd0, tx_serial}, 32'd1);
    check("arst_active", {31'd0, tx_active}, 32'd0);
    check("arst_done",   {31'd0, tx_done},   32'd0);
    check("arst_dv",     {31'd0, rx_dv},     32'd0);
    check("arst_err",    {31'd0, rx_err},    32'd0);
    check("arst_byte",   {24'd0, rx_byte},   32'h00);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    rx_drv = 1'b1;
    repeat (20) @(negedge clk);
    loop = 1'b1;
    send_tx(8'h81);
    wait_dv(dv_b + 1);
    repeat (10) @(negedge clk);
    check("post_rst_done", done_count - done_b, 32'd1);
    check("post_rst_dv", dv_count - dv_b, 32'd1);
    check("post_rst_err", err_count - err_b, 32'd0);
    check("post_rst_byte", {24'd0, rx_byte}, 32'h81);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
